key_event_ctrl: RTL and testbench

//  Debounces NUM_KEYS raw push-button inputs and turns each debounced press/release into an event.

---
 rtl/key_event_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// Key front end: per-key synchroniser and debouncer, press/release event
// scheduler, event FIFO and Avalon-MM register slave with a level interrupt.
module key_event_ctrl #(
  parameter int NUM_KEYS     = 4,
  parameter int CNT_W        = 20,
  parameter int DEF_DEBOUNCE = 50000,
  parameter int FIFO_AW      = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                read_n,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq,
  output logic [NUM_KEYS-1:0] key_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  // Bus handshake: Avalon-MM without waitrequest. A read or write is accepted
  // in any cycle where its strobe and chipselect are low/high respectively;
  // read data appears in readdata exactly one cycle later.
  logic rd, wr;
  assign rd = chipselect & ~read_n;
  assign wr = chipselect & ~write_n;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] stable_q, stable_d, chg;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [2:0]          ctrl_q, ctrl_d;
  logic [CNT_W-1:0]    deb_q, deb_d, p_last;
  logic [NUM_KEYS-1:0] pend_q, pend_d, ptype_q, ptype_d;
  logic                ovf_q, ovf_d;
  logic [8:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [31:0]         readdata_q, readdata_d;

  logic                enable, rel_en;
  logic                push_req, do_push, drop, pop, full, flush, ctrl_wr, deb_wr, stat_wr;
  logic [NUM_KEYS-1:0] push_oh;
  logic [7:0]          push_idx;
  logic                push_type;
  logic                unused_wdata;

  assign unused_wdata = ^writedata;
  assign enable  = ctrl_q[0];
  assign rel_en  = ctrl_q[2];
  assign ctrl_wr = wr && (address == 3'd1);
  assign deb_wr  = wr && (address == 3'd2);
  assign stat_wr = wr && (address == 3'd4);
  assign flush   = stat_wr && writedata[17];
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = rd && (address == 3'd3) && (count_q != '0);

  // A zero period debounces like a period of one.
  assign p_last = (deb_q == '0) ? '0 : deb_q - 1'b1;

  always_comb begin
    stable_d = stable_q;
    chg      = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (~sync2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] >= p_last) begin
        stable_d[k] = ~sync2_q[k];
        cnt_d[k]    = '0;
        chg[k]      = 1'b1;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // Lowest-index pending key wins the single push slot.
  always_comb begin
    push_oh   = '0;
    push_idx  = '0;
    push_type = 1'b0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        push_oh      = '0;
        push_oh[k]   = 1'b1;
        push_idx     = 8'(k);
        push_type    = ptype_q[k];
      end
    end
  end

  assign push_req = enable && (pend_q != '0);
  assign do_push  = push_req && !flush && (!full || pop);
  assign drop     = push_req && !flush && full && !pop;

  always_comb begin
    pend_d  = pend_q;
    ptype_d = ptype_q;
    ovf_d   = ovf_q;
    if (push_req) pend_d = pend_d & ~push_oh;
    if (stat_wr && writedata[16]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (chg[k] && enable && (stable_d[k] || rel_en)) begin
        if (pend_q[k] && !(push_req && push_oh[k])) ovf_d = 1'b1;
        pend_d[k]  = 1'b1;
        ptype_d[k] = stable_d[k];
      end
    end
    if (!enable || flush) pend_d = '0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(do_push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    count_d  = count_q + CW'(do_push) - CW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    deb_d  = deb_q;
    if (ctrl_wr) ctrl_d = writedata[2:0];
    if (deb_wr)  deb_d  = writedata[CNT_W-1:0];
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0: readdata_d = 32'(stable_q);
      3'd1: readdata_d = 32'(ctrl_q);
      3'd2: readdata_d = 32'(deb_q);
      3'd3: readdata_d = (count_q != '0) ? {1'b1, 22'b0, mem_q[rd_ptr_q]} : 32'h0;
      3'd4: readdata_d = {14'b0, 1'b0, ovf_q, 16'(count_q)};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      stable_q   <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
      ctrl_q     <= '0;
      deb_q      <= CNT_W'(DEF_DEBOUNCE);
      pend_q     <= '0;
      ptype_q    <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
      ctrl_q     <= ctrl_d;
      deb_q      <= deb_d;
      pend_q     <= pend_d;
      ptype_q    <= ptype_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_type, push_idx};
  end

  assign readdata  = readdata_q;
  assign key_state = stable_q;
  assign irq       = ctrl_q[1] & ((count_q != '0) | ovf_q);

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: debounce timing, event ordering, FIFO
// overflow/flush corner cases and asynchronous reset.
module tb_key_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  key_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  key_event_ctrl #(.NUM_KEYS(4), .CNT_W(20), .DEF_DEBOUNCE(50000), .FIFO_AW(3)) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq), .key_state(key_state)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(posedge clk);
    #1;
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic set_keys(input logic [3:0] v);
    @(negedge clk);
    key_in = v;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; key_in = 4'hF; address = '0; chipselect = 1'b0;
    read_n = 1'b1; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (readdata !== 32'h0) $display("FAIL rst_readdata: got %h expected 0", readdata); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", irq); else pass_cnt++;
    total_cnt++; if (key_state !== 4'h0) $display("FAIL rst_key_state: got %h expected 0", key_state); else pass_cnt++;
    reset_n = 1'b1;
    bus_read(3'd2, d);
    total_cnt++; if (d !== 32'd50000) $display("FAIL rst_debounce: got %0d expected 50000", d); else pass_cnt++;
    bus_read(3'd1, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL rst_ctrl: got %h expected 0", d); else pass_cnt++;
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL rst_status: got %h expected 0", d); else pass_cnt++;
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    bus_write(3'd2, 32'd4);
    bus_write(3'd1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      set_keys(4'b1110);
      repeat (2) @(negedge clk);
      set_keys(4'b1111);
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    total_cnt++; if (key_state !== 4'h0) $display("FAIL glitch_key_state: got %h expected 0", key_state); else pass_cnt++;
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL glitch_status: got %h expected 0", d); else pass_cnt++;
    set_keys(4'b1110);
    repeat (5) @(posedge clk);
    #1;
    total_cnt++; if (key_state !== 4'h0) $display("FAIL press_early: got %h expected 0", key_state); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (key_state !== 4'h1) $display("FAIL press_on_time: got %h expected 1", key_state); else pass_cnt++;
    repeat (2) @(posedge clk);
    bus_read(3'd3, d);
    total_cnt++; if (d !== 32'h8000_0100) $display("FAIL press_event: got %h expected 80000100", d); else pass_cnt++;
    set_keys(4'b1111);
    repeat (10) @(negedge clk);
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL no_release_event: got %h expected 0", d); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    bus_write(3'd1, 32'h3);
    set_keys(4'b1010);
    repeat (7) @(posedge clk);
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h1) $display("FAIL sim_count_first: got %h expected 1", d); else pass_cnt++;
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h2) $display("FAIL sim_count_second: got %h expected 2", d); else pass_cnt++;
    total_cnt++; if (irq !== 1'b1) $display("FAIL sim_irq: got %b expected 1", irq); else pass_cnt++;
    total_cnt++; if (key_state !== 4'b0101) $display("FAIL sim_key_state: got %h expected 5", key_state); else pass_cnt++;
    bus_read(3'd3, d);
    total_cnt++; if (d !== 32'h8000_0100) $display("FAIL sim_event0: got %h expected 80000100", d); else pass_cnt++;
    bus_read(3'd3, d);
    total_cnt++; if (d !== 32'h8000_0102) $display("FAIL sim_event2: got %h expected 80000102", d); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL sim_irq_clear: got %b expected 0", irq); else pass_cnt++;
    set_keys(4'b1111);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic        ok;
    for (int i = 0; i < 9; i++) begin
      set_keys(4'b1101);
      repeat (8) @(negedge clk);
      set_keys(4'b1111);
      repeat (8) @(negedge clk);
    end
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h0001_0008) $display("FAIL ovf_status: got %h expected 00010008", d); else pass_cnt++;
    bus_write(3'd4, 32'h0001_0000);
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h0000_0008) $display("FAIL ovf_cleared: got %h expected 00000008", d); else pass_cnt++;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_read(3'd3, d);
      if (d !== 32'h8000_0101) ok = 1'b0;
    end
    total_cnt++; if (ok !== 1'b1) $display("FAIL ovf_entries: got %b expected 1", ok); else pass_cnt++;
    total_cnt++; if (irq !== 1'b1) $display("FAIL ovf_irq_before_last: got %b expected 1", irq); else pass_cnt++;
    bus_read(3'd3, d);
    total_cnt++; if (d !== 32'h8000_0101) $display("FAIL ovf_last_entry: got %h expected 80000101", d); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL ovf_irq_after_last: got %b expected 0", irq); else pass_cnt++;
  endtask

  task automatic test_fifo_edges();
    logic [31:0] d;
    logic        ok;
    bus_read(3'd3, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL empty_pop: got %h expected 0", d); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      set_keys(4'b1101);
      repeat (8) @(negedge clk);
      set_keys(4'b1111);
      repeat (8) @(negedge clk);
    end
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h8) $display("FAIL full_status: got %h expected 8", d); else pass_cnt++;
    set_keys(4'b0111);
    repeat (6) @(posedge clk);
    bus_read(3'd3, d);
    total_cnt++; if (d !== 32'h8000_0101) $display("FAIL full_pop_head: got %h expected 80000101", d); else pass_cnt++;
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h8) $display("FAIL full_push_pop_count: got %h expected 8", d); else pass_cnt++;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_read(3'd3, d);
      if (d !== 32'h8000_0101) ok = 1'b0;
    end
    total_cnt++; if (ok !== 1'b1) $display("FAIL full_drain: got %b expected 1", ok); else pass_cnt++;
    bus_read(3'd3, d);
    total_cnt++; if (d !== 32'h8000_0103) $display("FAIL full_last_key3: got %h expected 80000103", d); else pass_cnt++;
    set_keys(4'b1111);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_disabled_p0();
    logic [31:0] d;
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h0);
    set_keys(4'b1110);
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (key_state !== 4'h0) $display("FAIL p0_early: got %h expected 0", key_state); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (key_state !== 4'h1) $display("FAIL p0_on_time: got %h expected 1", key_state); else pass_cnt++;
    set_keys(4'b1111);
    repeat (6) @(negedge clk);
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL disabled_no_event: got %h expected 0", d); else pass_cnt++;
    bus_write(3'd2, 32'd4);
    bus_write(3'd1, 32'h3);
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] d;
    set_keys(4'b0011);
    repeat (6) @(posedge clk);
    bus_write(3'd4, 32'h0002_0000);
    repeat (5) @(negedge clk);
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL flush_status: got %h expected 0", d); else pass_cnt++;
    set_keys(4'b1111);
    repeat (10) @(negedge clk);
    set_keys(4'b1101);
    repeat (12) @(negedge clk);
    total_cnt++; if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b expected 1", irq); else pass_cnt++;
    set_keys(4'b1100);
    address = 3'd1;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (readdata !== 32'h0) $display("FAIL mid_rst_readdata: got %h expected 0", readdata); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL mid_rst_irq: got %b expected 0", irq); else pass_cnt++;
    total_cnt++; if (key_state !== 4'h0) $display("FAIL mid_rst_key_state: got %h expected 0", key_state); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd2, d);
    total_cnt++; if (d !== 32'd50000) $display("FAIL mid_rst_debounce: got %0d expected 50000", d); else pass_cnt++;
    bus_read(3'd4, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL mid_rst_status: got %h expected 0", d); else pass_cnt++;
    set_keys(4'b1111);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_simultaneous();
    test_overflow();
    test_fifo_edges();
    test_disabled_p0();
    test_flush_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
